// File: rtl/nco_pkg.sv
// nco_pkg: shared definitions for the NCO divisor scheduler.
//   - Default values for the smallest legal divisor and the reset divisor
//     (1 Hz from a 50 MHz system clock).
//   - FSM state encoding used by nco_sched.
// No ports.
package nco_pkg;

    localparam int MIN_DIV_DEF = 4;
    localparam int RST_DIV_DEF = 50_000_000;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_ARB       = 2'd1;
    localparam logic [1:0] ST_WAIT_EDGE = 2'd2;

endpackage

// File: rtl/nco_core.sv
// nco_core: half-period counter and output toggle of the oscillator.
// Ports:
//   clk     in   system clock
//   rst_n   in   asynchronous active-low reset
//   half    in   W  half-period length in clk cycles (divisor >> 1)
//   clk_out out  divided clock, toggles at the end of every half-period
//   tick    out  one-cycle pulse, registered together with each clk_out toggle
module nco_core #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] half,
    output logic         clk_out,
    output logic         tick
);

    logic [W-1:0] cnt_q, cnt_d;
    logic         clk_q, clk_d;
    logic         tick_q, tick_d;
    logic         wrap;

    // cnt >= half-1 written as cnt+1 >= half in W+1 bits so that half==0
    // cannot underflow into a huge terminal count.
    assign wrap = ({1'b0, cnt_q} + {{W{1'b0}}, 1'b1}) >= {1'b0, half};

    always_comb begin
        cnt_d  = wrap ? '0 : cnt_q + 1'b1;
        clk_d  = clk_q ^ wrap;
        tick_d = wrap;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            clk_q  <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            clk_q  <= clk_d;
            tick_q <= tick_d;
        end
    end

    assign clk_out = clk_q;
    assign tick    = tick_q;

endmodule

// File: rtl/nco_sched.sv
// nco_sched: numerically controlled oscillator shared by NREQ requesters.
// Requesters ask for a new divisor; a round-robin arbiter grants one request
// at a time, rejects illegal divisors (odd or below MIN_DIV) and applies a
// legal one only at a clk_out toggle so no half-period is cut or stretched.
// Ports:
//   clk         in   system clock
//   rst_n       in   asynchronous active-low reset
//   req         in   NREQ    level divisor-change requests, held until grant
//   req_num     in   NREQ*W  packed divisors, slice i = [i*W +: W]
//   grant       out  NREQ    one-hot one-cycle pulse: request i consumed
//   err         out  pulse with grant when the granted divisor is rejected
//   clk_out     out  divided clock
//   tick        out  one-cycle pulse on every clk_out toggle
//   active_num  out  W       divisor currently in force
//   busy        out  high while an accepted divisor waits for a toggle
module nco_sched
    import nco_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int W       = 32,
    parameter int MIN_DIV = MIN_DIV_DEF,
    parameter int RST_DIV = RST_DIV_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*W-1:0] req_num,
    output logic [NREQ-1:0]   grant,
    output logic              err,
    output logic              clk_out,
    output logic              tick,
    output logic [W-1:0]      active_num,
    output logic              busy
);

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [1:0]       state_q, state_d;
    logic [PTR_W-1:0] rr_q, rr_d;
    logic [NREQ-1:0]  grant_q, grant_d;
    logic             err_q, err_d;
    logic             busy_q, busy_d;
    logic [W-1:0]     active_q, active_d;
    logic [W-1:0]     pend_q, pend_d;

    logic             win_found;
    logic [PTR_W-1:0] win_idx;
    logic [W-1:0]     win_num;
    logic             core_tick;

    function automatic logic div_bad(input logic [W-1:0] d);
        return (d < W'(MIN_DIV)) || d[0];
    endfunction

    // Round-robin search: first asserted request at or after rr_q, wrapping.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!win_found && req[(int'(rr_q) + k) % NREQ]) begin
                win_found = 1'b1;
                win_idx   = PTR_W'((int'(rr_q) + k) % NREQ);
            end
        end
    end

    assign win_num = req_num[int'(win_idx)*W +: W];

    always_comb begin
        state_d  = state_q;
        rr_d     = rr_q;
        grant_d  = '0;
        err_d    = 1'b0;
        busy_d   = busy_q;
        active_d = active_q;
        pend_d   = pend_q;
        case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    state_d = ST_ARB;
                end
            end
            ST_ARB: begin
                // The request may have been withdrawn since IDLE saw it.
                if (win_found) begin
                    grant_d = NREQ'(1) << win_idx;
                    rr_d    = PTR_W'((int'(win_idx) + 1) % NREQ);
                    if (div_bad(win_num)) begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        pend_d  = win_num;
                        busy_d  = 1'b1;
                        state_d = ST_WAIT_EDGE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT_EDGE: begin
                // Loading during the tick cycle: the counter has just restarted
                // and only sees the new half from the next cycle on, so the
                // half-period that begins at this toggle uses the new divisor.
                if (core_tick) begin
                    active_d = pend_q;
                    busy_d   = 1'b0;
                    state_d  = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            rr_q     <= '0;
            grant_q  <= '0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
            active_q <= W'(RST_DIV);
        end else begin
            state_q  <= state_d;
            rr_q     <= rr_d;
            grant_q  <= grant_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
            active_q <= active_d;
        end
    end

    // Pending divisor is only meaningful in WAIT_EDGE, so it needs no reset.
    always_ff @(posedge clk) begin
        pend_q <= pend_d;
    end

    nco_core #(
        .W (W)
    ) u_core (
        .clk     (clk),
        .rst_n   (rst_n),
        .half    (active_q >> 1),
        .clk_out (clk_out),
        .tick    (core_tick)
    );

    assign grant      = grant_q;
    assign err        = err_q;
    assign tick       = core_tick;
    assign active_num = active_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_nco_sched.sv
// tb_nco_sched: directed bench for nco_sched (NREQ=4, W=32, MIN_DIV=4, RST_DIV=8).
// A behavioural model predicts every output each cycle; directed scenarios
// add hand-computed literal expectations.
module tb_nco_sched;

    localparam int NREQ    = 4;
    localparam int W       = 32;
    localparam int MIN_DIV = 4;
    localparam int RST_DIV = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NREQ-1:0]   req = '0;
    logic [NREQ*W-1:0] req_num = '0;
    logic [NREQ-1:0]   grant;
    logic              err, clk_out, tick, busy;
    logic [W-1:0]      active_num;

    always #10 clk = ~clk;

    nco_sched #(
        .NREQ(NREQ), .W(W), .MIN_DIV(MIN_DIV), .RST_DIV(RST_DIV)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_num(req_num),
        .grant(grant), .err(err), .clk_out(clk_out), .tick(tick),
        .active_num(active_num), .busy(busy)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Oscillator: a half-period lasts active/2 cycles; a new divisor takes
    // effect for the half-period that starts at the first toggle after it
    // was accepted. Scheduler: a request seen while idle is arbitrated on the
    // next cycle, the grant/err pulse appears one cycle after that.
    logic            m_clk, m_tick, m_err, m_busy;
    logic [NREQ-1:0] m_grant;
    logic [W-1:0]    m_active, m_pend;
    int              m_since, m_mode, m_rr;

    task automatic model_reset();
        m_clk = 0; m_tick = 0; m_err = 0; m_busy = 0; m_grant = '0;
        m_active = W'(RST_DIV); m_pend = '0; m_since = 0; m_mode = 0; m_rr = 0;
    endtask

    task automatic model_step();
        int half, was_mode, w;
        bit was_tick, found;
        logic [W-1:0] d;
        half     = int'(m_active >> 1);
        was_tick = m_tick;
        was_mode = m_mode;
        m_grant  = '0;
        m_err    = 0;
        m_since++;
        if (m_since >= half) begin
            m_clk = ~m_clk; m_tick = 1; m_since = 0;
        end else begin
            m_tick = 0;
        end
        case (was_mode)
            0: if (req != '0) m_mode = 1;
            1: begin
                found = 0; w = 0;
                for (int k = 0; k < NREQ; k++) begin
                    if (!found && req[(m_rr + k) % NREQ]) begin found = 1; w = (m_rr + k) % NREQ; end
                end
                if (!found) begin
                    m_mode = 0;
                end else begin
                    d       = req_num[w*W +: W];
                    m_grant = NREQ'(1) << w;
                    m_rr    = (w + 1) % NREQ;
                    if (d < MIN_DIV || d[0]) begin
                        m_err = 1; m_mode = 0;
                    end else begin
                        m_pend = d; m_busy = 1; m_mode = 2;
                    end
                end
            end
            default: if (was_tick) begin m_active = m_pend; m_busy = 0; m_mode = 0; end
        endcase
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    // ---------------- per-cycle comparison ----------------
    initial begin
        forever begin
            @(negedge clk);
            check("clk_out",    64'(clk_out),    64'(m_clk));
            check("tick",       64'(tick),       64'(m_tick));
            check("grant",      64'(grant),      64'(m_grant));
            check("err",        64'(err),        64'(m_err));
            check("busy",       64'(busy),       64'(m_busy));
            check("active_num", 64'(active_num), 64'(m_active));
        end
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish, got time %0t required < 500000", $time);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        cyc(2);
        check("rst_clk_out", 64'(clk_out), 64'(0));
        check("rst_tick",    64'(tick),    64'(0));
        check("rst_grant",   64'(grant),   64'(0));
        check("rst_busy",    64'(busy),    64'(0));
        check("rst_active",  64'(active_num), 64'(8));
        rst_n = 1'b1;
    endtask

    task automatic wait_tick(input int bound, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!tick && n < bound);
        check("tick_wait", 64'(tick), 64'(1));
    endtask

    task automatic wait_grant(input int bound, output logic [NREQ-1:0] g);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (grant == '0 && n < bound);
        check("grant_wait", 64'(grant != '0), 64'(1));
        g = grant;
    endtask

    task automatic wait_not_busy(input int bound);
        int n;
        n = 0;
        while (busy && n < bound) begin
            @(negedge clk);
            n++;
        end
        check("busy_wait", 64'(busy), 64'(0));
    endtask

    task automatic set_num(input int i, input int v);
        req_num[i*W +: W] = W'(v);
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        int n;
        logic [NREQ-1:0] g;
        int order[4];

        // Reset release, no requests: toggle every 4 cycles.
        do_reset();
        wait_tick(20, n);
        check("first_toggle_cycles", 64'(n), 64'(4));
        check("first_toggle_level",  64'(clk_out), 64'(1));
        wait_tick(20, n);
        check("idle_half_period", 64'(n), 64'(4));

        // Accepted divisor 12 requested mid half-period.
        cyc(1);
        set_num(2, 12);
        req = 4'b0100;
        wait_grant(20, g);
        req = '0;
        check("grant2_onehot", 64'(g), 64'(4'b0100));
        check("grant2_busy",   64'(busy), 64'(1));
        wait_tick(20, n);
        check("old_half_completes", 64'(n), 64'(1));
        wait_tick(20, n);
        check("new_half_6_a", 64'(n), 64'(6));
        wait_tick(20, n);
        check("new_half_6_b", 64'(n), 64'(6));
        check("active_12", 64'(active_num), 64'(12));

        // Round robin with 1011 held.
        do_reset();
        for (int i = 0; i < NREQ; i++) set_num(i, 4);
        req = 4'b1011;
        for (int j = 0; j < 4; j++) begin
            wait_grant(40, g);
            order[j] = -1;
            for (int i = 0; i < NREQ; i++) if (g[i]) order[j] = i;
        end
        req = '0;
        check("rr_order_0", 64'(order[0]), 64'(0));
        check("rr_order_1", 64'(order[1]), 64'(1));
        check("rr_order_2", 64'(order[2]), 64'(3));
        check("rr_order_3", 64'(order[3]), 64'(0));
        cyc(10);

        // Rejected divisors: odd, then below minimum.
        do_reset();
        set_num(1, 7);
        req = 4'b0010;
        wait_grant(20, g);
        req = '0;
        check("rej7_grant", 64'(g), 64'(4'b0010));
        check("rej7_err",   64'(err), 64'(1));
        cyc(3);
        set_num(1, 2);
        req = 4'b0010;
        wait_grant(20, g);
        req = '0;
        check("rej2_grant", 64'(g), 64'(4'b0010));
        check("rej2_err",   64'(err), 64'(1));
        cyc(2);
        check("rej_busy",   64'(busy), 64'(0));
        check("rej_active", 64'(active_num), 64'(8));
        wait_tick(20, n);
        wait_tick(20, n);
        check("rej_half_4", 64'(n), 64'(4));

        // Request raised while another divisor waits for its toggle.
        do_reset();
        wait_tick(20, n);
        cyc(1);
        set_num(0, 16);
        req = 4'b0001;
        wait_grant(20, g);
        check("q_grant0", 64'(g), 64'(4'b0001));
        req = '0;
        set_num(3, 4);
        req = 4'b1000;
        check("q_busy", 64'(busy), 64'(1));
        wait_not_busy(20);
        check("q_active_16", 64'(active_num), 64'(16));
        wait_grant(40, g);
        req = '0;
        check("q_grant3", 64'(g), 64'(4'b1000));
        wait_not_busy(40);
        check("q_active_4", 64'(active_num), 64'(4));
        wait_tick(20, n);
        wait_tick(20, n);
        check("q_half_2", 64'(n), 64'(2));

        // Reset while a divisor is pending.
        do_reset();
        cyc(1);
        set_num(2, 20);
        req = 4'b0100;
        wait_grant(20, g);
        req = '0;
        cyc(1);
        check("pr_busy", 64'(busy), 64'(1));
        #3 rst_n = 1'b0;
        #1;
        check("ar_busy",    64'(busy), 64'(0));
        check("ar_active",  64'(active_num), 64'(8));
        check("ar_clk_out", 64'(clk_out), 64'(0));
        check("ar_grant",   64'(grant), 64'(0));
        check("ar_tick",    64'(tick), 64'(0));
        cyc(2);
        rst_n = 1'b1;
        wait_tick(20, n);
        check("ar_first_toggle", 64'(n), 64'(4));
        wait_tick(20, n);
        check("ar_half_4_a", 64'(n), 64'(4));
        wait_tick(20, n);
        check("ar_half_4_b", 64'(n), 64'(4));
        check("ar_active_8", 64'(active_num), 64'(8));

        cyc(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
